// File: rtl/frame_stream_src.sv
// Raster-order test-pattern frame source with valid/ready handshake and clock enable.
// Emits h*v pixels with sof/eol/eof markers, then pulses done for one enabled cycle.
module frame_stream_src #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SIZE_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce_i,
  input  logic                  start_i,
  input  logic [SIZE_WIDTH-1:0] h_size_i,
  input  logic [SIZE_WIDTH-1:0] v_size_i,
  input  logic [1:0]            pattern_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  eof_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e                state_q;
  logic [SIZE_WIDTH-1:0] h_q, v_q, x_q, y_q;
  logic [1:0]            pat_q;
  logic [DATA_WIDTH-1:0] seed_q, acc_q, data_q;
  logic                  sof_q, eol_q, eof_q;

  logic [SIZE_WIDTH-1:0] x_nxt, y_nxt;
  logic [DATA_WIDTH-1:0] acc_nxt, pix_nxt;
  logic                  eol_nxt, eof_nxt;

  // Position and pixel of the beat that follows the one currently presented.
  always_comb begin
    x_nxt   = eol_q ? '0 : x_q + 1'b1;
    y_nxt   = eol_q ? y_q + 1'b1 : y_q;
    acc_nxt = acc_q + 1'b1;
    unique case (pat_q)
      2'd0:    pix_nxt = acc_nxt;
      2'd1:    pix_nxt = seed_q;
      2'd2:    pix_nxt = seed_q + DATA_WIDTH'(x_nxt);
      2'd3:    pix_nxt = seed_q + DATA_WIDTH'(y_nxt);
      default: pix_nxt = seed_q;
    endcase
    eol_nxt = (x_nxt == h_q - 1'b1);
    eof_nxt = eol_nxt && (y_nxt == v_q - 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pat_q   <= '0;
      seed_q  <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else if (ce_i) begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (h_size_i != '0 && v_size_i != '0) begin
              h_q     <= h_size_i;
              v_q     <= v_size_i;
              pat_q   <= pattern_i;
              seed_q  <= seed_i;
              x_q     <= '0;
              y_q     <= '0;
              acc_q   <= seed_i;
              data_q  <= seed_i;
              sof_q   <= 1'b1;
              eol_q   <= (h_size_i == SIZE_WIDTH'(1));
              eof_q   <= (h_size_i == SIZE_WIDTH'(1)) && (v_size_i == SIZE_WIDTH'(1));
              state_q <= StStream;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StStream: begin
          if (ready_i) begin
            if (eof_q) begin
              state_q <= StDone;
              x_q     <= '0;
              y_q     <= '0;
              data_q  <= '0;
              sof_q   <= 1'b0;
              eol_q   <= 1'b0;
              eof_q   <= 1'b0;
            end else begin
              x_q     <= x_nxt;
              y_q     <= y_nxt;
              acc_q   <= acc_nxt;
              data_q  <= pix_nxt;
              sof_q   <= 1'b0;
              eol_q   <= eol_nxt;
              eof_q   <= eof_nxt;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign valid_o = (state_q == StStream);
  assign busy_o  = (state_q != StIdle);
  assign done_o  = (state_q == StDone);
  assign data_o  = data_q;
  assign sof_o   = sof_q;
  assign eol_o   = eol_q;
  assign eof_o   = eof_q;

endmodule
